// File: rtl/img_downscale.sv
`default_nettype none
// ============================================================================
// Module   : img_downscale
// Brief    : Reads a SRC_W x SRC_H source image from a 1-cycle-latency ROM
//            and writes a 1/f scaled image (f = 1, 2 or 4) to a RAM, either
//            by top-left decimation or by f x f block averaging.
// Revision : 1.0 - initial release
// ============================================================================
module img_downscale #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        fator,
    input  logic              mode,
    input  logic [PIX_W-1:0]  pixel_rom,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_CW = 16;          // output coordinate counter width
    localparam int c_AW = PIX_W + 4;   // accumulator width, holds 16 full-scale samples

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sh;          // log2 of the latched scale factor
    logic              r_mode;
    logic [c_CW-1:0]   r_ox;
    logic [c_CW-1:0]   r_oy;
    logic [2:0]        r_dx;
    logic [2:0]        r_dy;
    logic [c_AW-1:0]   r_acc;
    logic              r_rd_pend;     // a ROM read was issued last cycle
    logic [ADDR_W-1:0] r_pix_base;    // source address of the current block's top-left
    logic [ADDR_W-1:0] r_row_base;    // source address of the current output row's first block
    logic [ADDR_W-1:0] r_out_addr;    // next destination address, row-major

    logic              w_fator_ok;
    logic [1:0]        w_sh_new;
    logic [2:0]        w_fm1;
    logic [c_CW-1:0]   w_ow;
    logic [c_CW-1:0]   w_oh;
    logic              w_last_rd;
    logic [c_AW-1:0]   w_sum;
    logic [2:0]        w_shift;
    logic [ADDR_W-1:0] w_row_step;
    logic [ADDR_W-1:0] w_col_step;
    logic [ADDR_W-1:0] w_blk_step;

    // Decode the requested factor, derive frame geometry and address steps by shifting only
    always_comb begin
        w_fator_ok = (fator == 3'd1) || (fator == 3'd2) || (fator == 3'd4);
        w_sh_new   = (fator == 3'd4) ? 2'd2 : ((fator == 3'd2) ? 2'd1 : 2'd0);
        w_fm1      = (3'd1 << r_sh) - 3'd1;
        w_ow       = c_CW'(SRC_W >> r_sh);
        w_oh       = c_CW'(SRC_H >> r_sh);
        w_last_rd  = !r_mode || ((r_dx == w_fm1) && (r_dy == w_fm1));
        w_sum      = r_acc + c_AW'(pixel_rom);
        w_shift    = r_mode ? {r_sh, 1'b0} : 3'd0;
        w_row_step = ADDR_W'(SRC_W) << r_sh;
        w_col_step = ADDR_W'(1) << r_sh;
        w_blk_step = ADDR_W'(SRC_W) - ADDR_W'(w_fm1);
    end

    // Frame sequencer: READ issues addresses, DRAIN folds in the last sample, WRITE emits a pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sh       <= 2'd0;
            r_mode     <= 1'b0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_dx       <= 3'd0;
            r_dy       <= 3'd0;
            r_acc      <= '0;
            r_rd_pend  <= 1'b0;
            r_pix_base <= '0;
            r_row_base <= '0;
            r_out_addr <= '0;
            rom_addr   <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_fator_ok) begin
                            r_sh       <= w_sh_new;
                            r_mode     <= mode;
                            r_ox       <= '0;
                            r_oy       <= '0;
                            r_dx       <= 3'd0;
                            r_dy       <= 3'd0;
                            r_acc      <= '0;
                            r_rd_pend  <= 1'b0;
                            r_pix_base <= '0;
                            r_row_base <= '0;
                            r_out_addr <= '0;
                            rom_addr   <= '0;
                            busy       <= 1'b1;
                            r_state    <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_rd_pend <= 1'b1;
                    if (r_rd_pend) begin
                        r_acc <= w_sum;
                    end
                    if (w_last_rd) begin
                        r_dx    <= 3'd0;
                        r_dy    <= 3'd0;
                        r_state <= DRAIN;
                    end else if (r_dx == w_fm1) begin
                        r_dx     <= 3'd0;
                        r_dy     <= r_dy + 3'd1;
                        rom_addr <= rom_addr + w_blk_step;
                    end else begin
                        r_dx     <= r_dx + 3'd1;
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    r_rd_pend  <= 1'b0;
                    ram_data   <= PIX_W'(w_sum >> w_shift);
                    ram_addr   <= r_out_addr;
                    ram_we     <= 1'b1;
                    r_out_addr <= r_out_addr + ADDR_W'(1);
                    r_state    <= WRITE;
                end
                WRITE: begin
                    ram_we <= 1'b0;
                    r_acc  <= '0;
                    if (r_ox == w_ow - c_CW'(1)) begin
                        r_ox <= '0;
                        if (r_oy == w_oh - c_CW'(1)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_oy       <= r_oy + c_CW'(1);
                            r_row_base <= r_row_base + w_row_step;
                            r_pix_base <= r_row_base + w_row_step;
                            rom_addr   <= r_row_base + w_row_step;
                            r_state    <= READ;
                        end
                    end else begin
                        r_ox       <= r_ox + c_CW'(1);
                        r_pix_base <= r_pix_base + w_col_step;
                        rom_addr   <= r_pix_base + w_col_step;
                        r_state    <= READ;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_downscale.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_downscale
// Brief    : Directed/randomized bench for img_downscale with a ROM model and
//            a frame-level reference model of the scaled image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_downscale;

    localparam int SRC_W  = 160;
    localparam int SRC_H  = 120;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 19;
    localparam int NPIX   = SRC_W * SRC_H;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        fator;
    logic              mode;
    logic [PIX_W-1:0]  pixel_rom;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_data;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic              err;

    img_downscale #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fator    (fator),
        .mode     (mode),
        .pixel_rom(pixel_rom),
        .rom_addr (rom_addr),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:NPIX-1];
    int         exp_mem [0:NPIX-1];

    int n_assert = 0;
    int n_fail   = 0;

    // monitor state
    int cyc = 0;
    int wr_cnt, data_err, order_err, gap_err, exp_gap, last_wr_cyc, last_wr_addr;
    int first_wr_data, data81, done_cnt, done_cyc, err_cnt, busy_run, last_busy_len;
    int busy_rise_cyc, busy_total, we_in_rst, bad_addr, bad_data;
    logic prev_busy = 1'b0;

    int b_done_cyc, n_keep;

    // synchronous ROM: data for the address presented in one cycle appears the next
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (int'(rom_addr) < NPIX) pixel_rom <= rom_mem[int'(rom_addr)];
        else                       pixel_rom <= 8'h00;
    end

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) we_in_rst = we_in_rst + 1;
            prev_busy = 1'b0;
            busy_run  = 0;
        end else begin
            if (ram_we) begin
                if (int'(ram_addr) != wr_cnt) order_err = order_err + 1;
                if (int'(ram_addr) >= NPIX || int'(ram_data) != exp_mem[int'(ram_addr)]) begin
                    if (data_err == 0) begin
                        bad_addr = int'(ram_addr);
                        bad_data = int'(ram_data);
                    end
                    data_err = data_err + 1;
                end
                if (wr_cnt > 0 && (cyc - last_wr_cyc) != exp_gap) gap_err = gap_err + 1;
                if (wr_cnt == 0) first_wr_data = int'(ram_data);
                if (int'(ram_addr) == 81) data81 = int'(ram_data);
                last_wr_cyc  = cyc;
                last_wr_addr = int'(ram_addr);
                wr_cnt       = wr_cnt + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (err) err_cnt = err_cnt + 1;
            if (busy) begin
                busy_run   = busy_run + 1;
                busy_total = busy_total + 1;
                if (!prev_busy) busy_rise_cyc = cyc;
            end else if (prev_busy) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert = n_assert + 1;
        assert (obs === expv) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; data_err = 0; order_err = 0; gap_err = 0; last_wr_cyc = 0;
        last_wr_addr = -1; first_wr_data = -1; data81 = -1; done_cnt = 0; done_cyc = -1;
        err_cnt = 0; busy_run = 0; last_busy_len = -1; busy_rise_cyc = -1; busy_total = 0;
        we_in_rst = 0; bad_addr = -1; bad_data = -1;
    endtask

    // reference: one output pixel straight from the scaling rule
    function automatic int model_px(int f, int m, int ox, int oy);
        int s;
        s = 0;
        if (m == 0) return int'(rom_mem[(oy * f) * SRC_W + ox * f]);
        for (int dy = 0; dy < f; dy++)
            for (int dx = 0; dx < f; dx++)
                s += int'(rom_mem[(oy * f + dy) * SRC_W + ox * f + dx]);
        return s / (f * f);
    endfunction

    task automatic build_model(input int f, input int m);
        for (int i = 0; i < NPIX; i++) exp_mem[i] = -1;
        for (int oy = 0; oy < SRC_H / f; oy++)
            for (int ox = 0; ox < SRC_W / f; ox++)
                exp_mem[oy * (SRC_W / f) + ox] = model_px(f, m, ox, oy);
    endtask

    task automatic pulse_start(input int f, input int m);
        @(negedge clk);
        fator = 3'(f);
        mode  = m[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != 0) break;
        end
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (wr_cnt >= n) break;
        end
    endtask

    task automatic abort_with_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_rst_rom_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, "_rst_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_rst_ram_data"}, 64'(ram_data), 64'd0);
        chk({tag, "_rst_flags"}, 64'({ram_we, busy, done, err}), 64'd0);
        n_keep = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk({tag, "_no_write_after_rst"}, 64'(wr_cnt), 64'(n_keep));
        chk({tag, "_no_done_aborted"}, 64'(done_cnt), 64'd0);
        chk({tag, "_idle_after_rst"}, 64'(busy), 64'd0);
        chk({tag, "_we_in_rst"}, 64'(we_in_rst), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; fator = 3'd0; mode = 1'b0;
        clear_mon();
        for (int i = 0; i < NPIX; i++) begin
            rom_mem[i] = 8'(i);
            exp_mem[i] = -1;
        end

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        chk("reset_ram_addr", 64'(ram_addr), 64'd0);
        chk("reset_ram_data", 64'(ram_data), 64'd0);
        chk("reset_flags", 64'({ram_we, busy, done, err}), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", 64'({ram_we, busy, done, err}), 64'd0);

        // illegal factors
        clear_mon();
        pulse_start(3, 0);
        repeat (5) @(negedge clk);
        chk("err3_pulse_cycles", 64'(err_cnt), 64'd1);
        chk("err3_quiet", 64'(busy_total + wr_cnt + done_cnt), 64'd0);
        clear_mon();
        pulse_start(0, 1);
        repeat (5) @(negedge clk);
        chk("err0_pulse_cycles", 64'(err_cnt), 64'd1);
        chk("err0_quiet", 64'(busy_total + wr_cnt + done_cnt), 64'd0);

        // mode 0, f=2 on an address ramp; start stays high to chain the next frame
        clear_mon();
        build_model(2, 0);
        exp_gap = 3;
        @(negedge clk);
        fator = 3'd2; mode = 1'b0; start = 1'b1;
        repeat (20) @(negedge clk);
        fator = 3'd3;
        repeat (20) @(negedge clk);
        fator = 3'd4;
        wait_done(16000);
        b_done_cyc = done_cyc;
        chk("m0f2_writes", 64'(wr_cnt), 64'd4800);
        chk("m0f2_data_errs", 64'(data_err), 64'd0);
        chk("m0f2_order_errs", 64'(order_err), 64'd0);
        chk("m0f2_gap_errs", 64'(gap_err), 64'd0);
        chk("m0f2_addr81_data", 64'(data81), 64'd66);
        chk("m0f2_busy_len", 64'(last_busy_len), 64'd14400);
        chk("m0f2_done_once", 64'(done_cnt), 64'd1);
        chk("m0f2_no_err_midframe", 64'(err_cnt), 64'd0);
        if (data_err != 0) $display("first bad write addr %0d data %0d", bad_addr, bad_data);

        // second frame starts from held start with fator=4 mode 0
        clear_mon();
        build_model(4, 0);
        exp_gap = 3;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(5000);
        chk("chain_restart_cycle", 64'(busy_rise_cyc), 64'(b_done_cyc + 2));
        chk("m0f4_writes", 64'(wr_cnt), 64'd1200);
        chk("m0f4_last_addr", 64'(last_wr_addr), 64'd1199);
        chk("m0f4_data_errs", 64'(data_err), 64'd0);
        chk("m0f4_busy_len", 64'(last_busy_len), 64'd3600);
        chk("m0f4_done_once", 64'(done_cnt), 64'd1);
        repeat (5) @(negedge clk);
        chk("single_chain_only", 64'(busy), 64'd0);

        // mode 1, f=4, saturated source, aborted by reset
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'hFF;
        clear_mon();
        build_model(4, 1);
        exp_gap = 18;
        pulse_start(4, 1);
        wait_wr(40, 1000);
        chk("m1f4_progress", 64'(wr_cnt >= 40), 64'd1);
        chk("m1f4_first_data", 64'(first_wr_data), 64'd255);
        chk("m1f4_data_errs", 64'(data_err), 64'd0);
        chk("m1f4_gap_errs", 64'(gap_err), 64'd0);
        abort_with_reset("m1f4");

        // mode 1, f=2, random source with a known first block, aborted by reset
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'd10; rom_mem[1] = 8'd20;
        rom_mem[SRC_W] = 8'd30; rom_mem[SRC_W + 1] = 8'd41;
        clear_mon();
        build_model(2, 1);
        exp_gap = 6;
        pulse_start(2, 1);
        wait_wr(100, 1000);
        chk("m1f2_progress", 64'(wr_cnt >= 100), 64'd1);
        chk("m1f2_first_block", 64'(first_wr_data), 64'd25);
        chk("m1f2_data_errs", 64'(data_err), 64'd0);
        chk("m1f2_order_errs", 64'(order_err), 64'd0);
        chk("m1f2_gap_errs", 64'(gap_err), 64'd0);
        abort_with_reset("m1f2");

        // fresh frame after reset: f=1 copy of random source
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'($urandom);
        clear_mon();
        build_model(1, 0);
        exp_gap = 3;
        pulse_start(1, 0);
        wait_done(60000);
        chk("f1_writes", 64'(wr_cnt), 64'd19200);
        chk("f1_last_addr", 64'(last_wr_addr), 64'd19199);
        chk("f1_data_errs", 64'(data_err), 64'd0);
        chk("f1_order_errs", 64'(order_err), 64'd0);
        chk("f1_busy_len", 64'(last_busy_len), 64'd57600);
        chk("f1_done_once", 64'(done_cnt), 64'd1);
        if (data_err != 0) $display("first bad write addr %0d data %0d", bad_addr, bad_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/img_downscale.md
IMG_DOWNSCALE -- requirements
Module: img_downscale

Interface
REQ-001 Parameter SRC_W, default 160, source image width in pixels.
REQ-002 Parameter SRC_H, default 120, source image height in pixels.
REQ-003 Parameter PIX_W, default 8, pixel data width.
REQ-004 Parameter ADDR_W, default 19, ROM and RAM address width.
REQ-005 Port clk, input, 1, clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-low.
REQ-007 Port start, input, 1, single-cycle request to begin one frame.
REQ-008 Port fator, input, 3, scale factor; legal values are 1, 2 and 4; sampled on an accepted start.
REQ-009 Port mode, input, 1, operating mode sampled on an accepted start: 0 = decimate (top-left sample), 1 = block average.
REQ-010 Port pixel_rom, input, PIX_W, source pixel; valid exactly 1 cycle after rom_addr is presented.
REQ-011 Port rom_addr, output, ADDR_W, source read address.
REQ-012 Port ram_addr, output, ADDR_W, destination write address.
REQ-013 Port ram_data, output, PIX_W, destination write data.
REQ-014 Port ram_we, output, 1, destination write strobe, one cycle per output pixel.
REQ-015 Port busy, output, 1, frame in progress.
REQ-016 Port done, output, 1, one-cycle pulse marking frame completion.
REQ-017 Port err, output, 1, one-cycle pulse marking a rejected start.

Function
REQ-018 FSM states SHALL be IDLE, READ, DRAIN, WRITE and FIN.
- IDLE: waits for start.
- READ: issues one rom_addr per cycle.
- DRAIN: captures the last sample.
- WRITE: asserts ram_we.
- FIN: pulses done, then returns to IDLE.
REQ-019 A start in IDLE with legal fator SHALL latch fator and mode, clear ox, oy and the accumulator, assert busy from the next cycle and enter READ.
REQ-020 A start in IDLE with fator not in {1,2,4} SHALL pulse err for one cycle and remain in IDLE with busy=0.
REQ-021 start SHALL be ignored while busy=1; latched fator and mode SHALL NOT change mid-frame.
REQ-022 Output size SHALL be OW=SRC_W/f and OH=SRC_H/f (floor); remainder source columns and rows SHALL be skipped.
REQ-023 Each output pixel (ox,oy) SHALL read the source samples (oy*f+dy)*SRC_W+(ox*f+dx).
- Mode 1: dy and dx each span 0..f-1, dx varying fastest, giving f*f reads.
- Mode 0: a single read with dx=dy=0.
REQ-024 The accumulator SHALL be PIX_W+4 bits and SHALL add pixel_rom one cycle after each issued address.
REQ-025 In WRITE, ram_data SHALL equal acc>>log2(f*f) in mode 1 (shift 0, 2 or 4, truncating) and the single sample in mode 0.
- ram_addr SHALL equal oy*OW+ox.
- ram_we SHALL be 1 for exactly that cycle.
- The accumulator SHALL clear for the next output pixel.
REQ-026 Cycles per output pixel SHALL be 3 in mode 0 and f*f+2 in mode 1 (READ reads, DRAIN, WRITE).
REQ-027 After WRITE, ox SHALL increment.
- At ox=OW-1, ox wraps to 0 and oy increments.
- At ox=OW-1 and oy=OH-1, the FSM enters FIN.
REQ-028 FIN SHALL pulse done for one cycle, drop busy in the same cycle and return to IDLE; a start in the cycle after FIN SHALL be accepted.
REQ-029 Outside WRITE, ram_we SHALL be 0; ram_addr and ram_data SHALL hold their last values.
REQ-030 The address arithmetic SHALL use no divider; all products SHALL be computed at ADDR_W width without overflow for the default parameters.

Reset
REQ-031 While rst=0, all outputs and internal state SHALL be forced to 0 and the FSM to IDLE, including during a frame.
- No ram_we SHALL occur after reset asserts.
- done SHALL NOT pulse for the aborted frame.
REQ-032 After rst deasserts, the block SHALL take no action until a new start.

Verification
REQ-033 Mode 0, fator=2, source pixel = (addr mod 256): exactly 4800 writes; write to ram_addr 81 has ram_data = (322 mod 256) = 66; done pulses once; busy lasts 14400 cycles.
REQ-034 Mode 1, fator=2, 2x2 source block values 10, 20, 30, 41: ram_data = 25 (101>>2); 6 cycles per output pixel.
REQ-035 Mode 1, fator=4, all source pixels 255: every ram_data = 255, no overflow; 1200 writes, last ram_addr = 1199.
REQ-036 fator=3 and fator=0 start: err pulses for 1 cycle; busy, ram_we and done stay 0.
REQ-037 rst=0 asserted mid-frame: outputs 0 in the same cycle; a new start with fator=1 writes 19200 pixels with ram_addr equal to rom_addr.
REQ-038 start held high throughout a frame: exactly one frame; the next frame starts the cycle after the done pulse.
